// File: rtl/bus_fifo_slave.sv
// -----------------------------------------------------------------------------
// bus_fifo_slave
//
// Memory-mapped 64-bit FIFO slave for one slave port behind the single-master
// system bus. Writes go into a circular buffer; pop, peek and status reads are
// returned on s_dout one cycle after the access, matching the bus's
// registered read-data return path.
//
// Register map (s_address[2:0], upper address bits ignored):
//   0 PUSH    W: push s_din          R: 0
//   1 POP     R: head, then pop      W: ignored
//   2 STATUS  R: {48'b0, count[7:0], 4'b0, ovf, udf, full, empty}
//   3 CLEAR   W: empty FIFO, clear ovf/udf   R: 0
//   4 PEEK    R: head, no pop        W: ignored
//   5 THRESH  R/W 8-bit irq threshold (FIFO_IRQ_EN only, else unused)
//   6,7       R: 0, W: ignored
//
// Optional feature: define FIFO_IRQ_EN to add the threshold register and the
// irq output (irq = threshold != 0 && count >= threshold, registered).
//
// Parameters:
//   DEPTH      FIFO entries, power of two, 2..128
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   s_sel      slave select from the bus address decoder
//   s_wr       1 = write, 0 = read (qualified by s_sel)
//   s_address  slave address, only [2:0] decoded
//   s_din      write data
//   s_dout     registered read data, 0 when no read in the previous cycle
//   irq        threshold interrupt (FIFO_IRQ_EN only)
// -----------------------------------------------------------------------------
module bus_fifo_slave #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_sel,
  input  logic        s_wr,
  input  logic [15:0] s_address,
  input  logic [63:0] s_din,
  output logic [63:0] s_dout
`ifdef FIFO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    OFF_PUSH   = 3'd0,
    OFF_POP    = 3'd1,
    OFF_STATUS = 3'd2,
    OFF_CLEAR  = 3'd3,
    OFF_PEEK   = 3'd4,
    OFF_THRESH = 3'd5,
    OFF_RSVD6  = 3'd6,
    OFF_RSVD7  = 3'd7
  } reg_off_e;

  // State
  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_udf;
  logic [63:0]      r_dout;

  // Next-state
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_ovf_nxt;
  logic             w_udf_nxt;
  logic [63:0]      w_dout_nxt;
  logic             w_mem_we;

  // Decode
  reg_off_e         w_off;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_full;
  logic             w_empty;
  logic [63:0]      w_head;
  logic             w_unused_addr;

`ifdef FIFO_IRQ_EN
  logic [7:0]       r_thresh;
  logic             r_irq;
  logic [7:0]       w_thresh_nxt;
  logic             w_irq_nxt;
`endif

  assign w_off         = reg_off_e'(s_address[2:0]);
  assign w_wr_acc      = s_sel & s_wr;
  assign w_rd_acc      = s_sel & ~s_wr;
  assign w_full        = (r_count == FULL_CNT);
  assign w_empty       = (r_count == '0);
  assign w_head        = r_mem[r_rd_ptr];
  assign w_unused_addr = ^s_address[15:3];

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    w_ovf_nxt    = r_ovf;
    w_udf_nxt    = r_udf;
    w_dout_nxt   = '0;
    w_mem_we     = 1'b0;
`ifdef FIFO_IRQ_EN
    w_thresh_nxt = r_thresh;
`endif

    case (w_off)
      OFF_PUSH: begin
        if (w_wr_acc) begin
          if (w_full) begin
            w_ovf_nxt = 1'b1;            // data dropped, state untouched
          end else begin
            w_mem_we     = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            w_count_nxt  = r_count + CNT_W'(1);
          end
        end
      end
      OFF_POP: begin
        if (w_rd_acc) begin
          if (w_empty) begin
            w_udf_nxt = 1'b1;
          end else begin
            w_dout_nxt   = w_head;       // pre-pop head is returned
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
            w_count_nxt  = r_count - CNT_W'(1);
          end
        end
      end
      OFF_STATUS: begin
        if (w_rd_acc) begin
          w_dout_nxt = {48'b0, 8'(r_count), 4'b0, r_ovf, r_udf, w_full, w_empty};
        end
      end
      OFF_CLEAR: begin
        if (w_wr_acc) begin
          w_wr_ptr_nxt = '0;
          w_rd_ptr_nxt = '0;
          w_count_nxt  = '0;
          w_ovf_nxt    = 1'b0;
          w_udf_nxt    = 1'b0;
        end
      end
      OFF_PEEK: begin
        if (w_rd_acc && !w_empty) begin
          w_dout_nxt = w_head;
        end
      end
`ifdef FIFO_IRQ_EN
      OFF_THRESH: begin
        if (w_wr_acc) begin
          w_thresh_nxt = s_din[7:0];
        end else if (w_rd_acc) begin
          w_dout_nxt = {56'b0, r_thresh};
        end
      end
`endif
      default: ;
    endcase
  end

`ifdef FIFO_IRQ_EN
  // Evaluated on next-state values so the registered irq always equals the
  // threshold function of the registered count/threshold, and changes in the
  // cycle right after the causing access.
  assign w_irq_nxt = (w_thresh_nxt != 8'd0) && (8'(w_count_nxt) >= w_thresh_nxt);
`endif

  // NOTE: the storage array has no reset; its contents are only observable
  // through entries already counted as valid, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr] <= s_din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_dout   <= '0;
`ifdef FIFO_IRQ_EN
      r_thresh <= '0;
      r_irq    <= 1'b0;
`endif
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_ovf    <= w_ovf_nxt;
      r_udf    <= w_udf_nxt;
      r_dout   <= w_dout_nxt;
`ifdef FIFO_IRQ_EN
      r_thresh <= w_thresh_nxt;
      r_irq    <= w_irq_nxt;
`endif
    end
  end

  assign s_dout = r_dout;
`ifdef FIFO_IRQ_EN
  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_bus_fifo_slave.sv
// -----------------------------------------------------------------------------
// tb_bus_fifo_slave
//
// Self-checking bench for bus_fifo_slave. A queue-based reference model
// predicts read data, status and irq; directed scenarios check the documented
// boundary values and a randomized run compares every access to the model.
// -----------------------------------------------------------------------------
module tb_bus_fifo_slave;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_sel = 1'b0;
  logic        s_wr = 1'b0;
  logic [15:0] s_address = '0;
  logic [63:0] s_din = '0;
  logic [63:0] s_dout;
`ifdef FIFO_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [63:0] m_q[$];
  logic        m_ovf;
  logic        m_udf;
  logic [7:0]  m_thresh;

  bus_fifo_slave #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_address (s_address),
    .s_din     (s_din),
    .s_dout    (s_dout)
`ifdef FIFO_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_q.delete();
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_thresh = 8'd0;
  endfunction

  // Applies one access to the model and returns the data the bus should see.
  function automatic logic [63:0] model_step(input logic sel, input logic wr,
                                             input logic [2:0] off,
                                             input logic [63:0] din);
    logic [63:0] r;
    int          n;
    r = 64'd0;
    n = m_q.size();
    if (!sel) return r;
    case (off)
      3'd0: if (wr) begin
              if (n == DEPTH) m_ovf = 1'b1;
              else m_q.push_back(din);
            end
      3'd1: if (!wr) begin
              if (n == 0) m_udf = 1'b1;
              else r = m_q.pop_front();
            end
      3'd2: if (!wr) r = 64'(n) * 256 + (m_ovf ? 8 : 0) + (m_udf ? 4 : 0)
                         + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0);
      3'd3: if (wr) begin
              m_q.delete();
              m_ovf = 1'b0;
              m_udf = 1'b0;
            end
      3'd4: if (!wr && n != 0) r = m_q[0];
`ifdef FIFO_IRQ_EN
      3'd5: if (wr) m_thresh = din[7:0];
            else r = 64'(m_thresh);
`endif
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic model_irq();
    return (m_thresh != 8'd0) && (m_q.size() >= int'(m_thresh));
  endfunction

  // One bus cycle: drive at the falling edge, sample #1 after the rising edge.
  task automatic bus(input logic sel, input logic wr, input logic [2:0] off,
                     input logic [63:0] din, output logic [63:0] obs,
                     output logic [63:0] exp);
    exp = model_step(sel, wr, off, din);
    @(negedge clk);
    s_sel     = sel;
    s_wr      = wr;
    s_address = {13'($urandom), off};
    s_din     = din;
    @(posedge clk);
    #1;
    s_sel = 1'b0;
    obs   = s_dout;
  endtask

  task automatic test_reset();
    logic [63:0] obs, exp;
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (s_dout !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_dout: got %h expected 0", s_dout);
    end
`ifdef FIFO_IRQ_EN
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    bus(1, 0, 3'd2, 64'd0, obs, exp);
    n_checks++;
    if (obs !== 64'h1) begin
      n_fail++;
      $display("FAIL reset_status: got %h expected 1", obs);
    end
  endtask

  task automatic test_basic();
    logic [63:0] obs, exp;
    logic [63:0] want [4];
    want = '{64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0001, 64'h2, 64'h1};
    bus(1, 1, 3'd0, 64'hA5A5_0000_0000_0001, obs, exp);
    bus(1, 1, 3'd0, 64'h2, obs, exp);
    for (int i = 0; i < 4; i++) begin
      // peek, pop, pop, status
      bus(1, 0, (i == 0) ? 3'd4 : (i == 3) ? 3'd2 : 3'd1, 64'd0, obs, exp);
      n_checks++;
      if (obs !== want[i]) begin
        n_fail++;
        $display("FAIL basic_read%0d: got %h expected %h", i, obs, want[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] obs, exp;
    for (int i = 1; i <= DEPTH + 1; i++) bus(1, 1, 3'd0, 64'h1000 + 64'(i), obs, exp);
    bus(1, 0, 3'd2, 64'd0, obs, exp);
    n_checks++;
    if (obs !== 64'h080A) begin
      n_fail++;
      $display("FAIL ovf_status: got %h expected 080a", obs);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      bus(1, 0, 3'd1, 64'd0, obs, exp);
      n_checks++;
      if (obs !== 64'h1000 + 64'(i)) begin
        n_fail++;
        $display("FAIL ovf_pop%0d: got %h expected %h", i, obs, 64'h1000 + 64'(i));
      end
    end
    bus(1, 0, 3'd2, 64'd0, obs, exp);
    n_checks++;
    if (obs !== 64'h0009) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %h expected 0009", obs);
    end
  endtask

  task automatic test_underflow_clear();
    logic [63:0] obs, exp;
    logic [2:0]  off  [6];
    logic        wr   [6];
    logic [63:0] want [6];
    // clear, peek-empty, status, pop-empty, status, clear
    off  = '{3'd3, 3'd4, 3'd2, 3'd1, 3'd2, 3'd3};
    wr   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    want = '{64'h0, 64'h0, 64'h1, 64'h0, 64'h5, 64'h0};
    for (int i = 0; i < 6; i++) begin
      bus(1, wr[i], off[i], {$urandom, $urandom}, obs, exp);
      n_checks++;
      if (obs !== want[i]) begin
        n_fail++;
        $display("FAIL udf_step%0d: got %h expected %h", i, obs, want[i]);
      end
    end
    bus(1, 0, 3'd2, 64'd0, obs, exp);
    n_checks++;
    if (obs !== 64'h1) begin
      n_fail++;
      $display("FAIL clear_status: got %h expected 1", obs);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] obs, exp;
    logic [63:0] words [4];
    for (int i = 0; i < 4; i++) begin
      words[i] = {$urandom, $urandom};
      bus(1, 1, 3'd0, words[i], obs, exp);
    end
    for (int i = 0; i < 4; i++) begin
      bus(1, 0, 3'd1, 64'd0, obs, exp);
      n_checks++;
      if (obs !== words[i]) begin
        n_fail++;
        $display("FAIL b2b_pop%0d: got %h expected %h", i, obs, words[i]);
      end
    end
    // idle cycle: read data must drop back to 0
    bus(0, 0, 3'd4, 64'd0, obs, exp);
    n_checks++;
    if (obs !== 64'd0) begin
      n_fail++;
      $display("FAIL b2b_idle: got %h expected 0", obs);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] obs, exp;
    logic [63:0] first;
`ifdef FIFO_IRQ_EN
    bus(1, 1, 3'd5, 64'd2, obs, exp);
`endif
    first = {$urandom | 32'h1, $urandom};
    bus(1, 1, 3'd0, first, obs, exp);
    bus(1, 1, 3'd0, {$urandom, $urandom}, obs, exp);
    bus(1, 1, 3'd0, {$urandom, $urandom}, obs, exp);
    bus(1, 0, 3'd4, 64'd0, obs, exp);
    n_checks++;
    if (obs !== first) begin
      n_fail++;
      $display("FAIL rstmid_peek: got %h expected %h", obs, first);
    end
    reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (s_dout !== 64'd0) begin
      n_fail++;
      $display("FAIL rstmid_dout: got %h expected 0", s_dout);
    end
`ifdef FIFO_IRQ_EN
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_irq: got %b expected 0", irq);
    end
`endif
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus(1, 0, 3'd2, 64'd0, obs, exp);
    n_checks++;
    if (obs !== 64'h1) begin
      n_fail++;
      $display("FAIL rstmid_status: got %h expected 1", obs);
    end
  endtask

`ifdef FIFO_IRQ_EN
  task automatic test_irq();
    logic [63:0] obs, exp;
    logic        wr   [8];
    logic [2:0]  off  [8];
    logic [63:0] din  [8];
    logic        want [8];
    // thresh=3, push, push, push, pop, push, thresh=0, push
    wr   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    off  = '{3'd5, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd5, 3'd0};
    din  = '{64'hFF03, 64'h11, 64'h22, 64'h33, 64'h0, 64'h44, 64'h0, 64'h55};
    want = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bus(1, 1, 3'd3, 64'd0, obs, exp);
    for (int i = 0; i < 8; i++) begin
      bus(1, wr[i], off[i], din[i], obs, exp);
      n_checks++;
      if (irq !== want[i]) begin
        n_fail++;
        $display("FAIL irq_step%0d: got %b expected %b", i, irq, want[i]);
      end
    end
    bus(1, 0, 3'd5, 64'd0, obs, exp);
    n_checks++;
    if (obs !== 64'd0) begin
      n_fail++;
      $display("FAIL irq_thresh_read: got %h expected 0", obs);
    end
  endtask
`endif

  task automatic test_random();
    logic [63:0] obs, exp;
    logic        sel, wr;
    logic [2:0]  off;
    int          r;
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 19));
      sel = (r != 19);
      if (r < 7) begin
        off = 3'd0; wr = 1'b1;
      end else if (r < 12) begin
        off = 3'd1; wr = 1'b0;
      end else begin
        off = 3'($urandom_range(0, 7));
        wr  = 1'($urandom_range(0, 1));
        if (off == 3'd3 && wr && $urandom_range(0, 3) != 0) wr = 1'b0;
      end
      bus(sel, wr, off, {$urandom, $urandom}, obs, exp);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rand%0d off%0d wr%0b sel%0b: got %h expected %h",
                 i, off, wr, sel, obs, exp);
      end
`ifdef FIFO_IRQ_EN
      n_checks++;
      if (irq !== model_irq()) begin
        n_fail++;
        $display("FAIL rand_irq%0d: got %b expected %b", i, irq, model_irq());
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow_clear();
    test_back_to_back();
    test_reset_mid();
`ifdef FIFO_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
